// File: rtl/pio_pkg.sv
// Shared constants for the PIO program loader: states, action codes,
// register field offsets and the Wishbone address helper.
package pio_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_RST_REQ   = 3'd1;
  localparam state_t S_RST_ACK   = 3'd2;
  localparam state_t S_WAIT_WORD = 3'd3;
  localparam state_t S_WR_REQ    = 3'd4;
  localparam state_t S_WR_ACK    = 3'd5;
  localparam state_t S_FINISH    = 3'd6;

  localparam logic [3:0] ACT_CTRL  = 4'd0;
  localparam logic [3:0] ACT_INSTR = 4'd1;

  localparam logic [31:0] RST_WORD = 32'h8000_0000;

  localparam int MIDX_LSB = 6;
  localparam int ACT_LSB  = 2;

  localparam logic [5:0] MAX_LEN = 6'd32;

  function automatic logic [31:0] pio_adr(
    input logic [31:0] base,
    input logic [1:0]  midx,
    input logic [3:0]  act
  );
    pio_adr = base
            | (32'(midx) << MIDX_LSB)
            | (32'(act) << ACT_LSB);
  endfunction

endpackage

// File: rtl/pio_prog_loader_if.sv
// Bundle of the instruction stream and Wishbone master signals
// used around the PIO program loader.
interface pio_prog_loader_if;

  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;

  modport master (
    input  s_valid,
    output s_ready,
    input  s_data,
    output wbm_cyc_o,
    output wbm_stb_o,
    output wbm_we_o,
    output wbm_sel_o,
    output wbm_adr_o,
    output wbm_dat_o,
    input  wbm_ack_i
  );

  modport slave (
    output s_valid,
    input  s_ready,
    output s_data,
    input  wbm_cyc_o,
    input  wbm_stb_o,
    input  wbm_we_o,
    input  wbm_sel_o,
    input  wbm_adr_o,
    input  wbm_dat_o,
    output wbm_ack_i
  );

endinterface

// File: rtl/pio_prog_loader.sv
// Loads a PIO program over Wishbone: soft reset, then one write per word.
// Optional ack timeout with sticky err: define PIO_LOADER_TIMEOUT_EN.
module pio_prog_loader
  import pio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start,
  input  logic [5:0]  prog_len,
  input  logic [1:0]  tgt_mindex,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  words_loaded
);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  midx_q;
  logic [5:0]  len_q;
  logic [5:0]  wl_q;
  logic [5:0]  wl_inc;
  logic [15:0] data_q;
  logic        bus_req;
  logic        is_rst;
  logic        is_wr;
  logic        in_ack;
  logic        to_hit;

  assign is_rst  = (state == S_RST_REQ) || (state == S_RST_ACK);
  assign is_wr   = (state == S_WR_REQ) || (state == S_WR_ACK);
  assign in_ack  = (state == S_RST_ACK) || (state == S_WR_ACK);
  assign bus_req = is_rst || is_wr;
  assign wl_inc  = (wl_q >= MAX_LEN) ? MAX_LEN : wl_q + 6'd1;

`ifdef PIO_LOADER_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] to_cnt;
  logic        err_q;

  assign to_hit = in_ack && !wbm_ack_i && (to_cnt == TO_LAST);
  assign err    = err_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= in_ack ? to_cnt + 32'd1 : '0;
      if (state == S_IDLE && start)
        err_q <= 1'b0;
      else if (to_hit)
        err_q <= 1'b1;
    end
  end
`else
  logic unused_to;

  assign unused_to = ^{32'(TIMEOUT_CYCLES), in_ack};
  assign to_hit    = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (start) state_nx = S_RST_REQ;
      S_RST_REQ, S_RST_ACK:
        if (wbm_ack_i)
          state_nx = (len_q == 6'd0) ? S_FINISH : S_WAIT_WORD;
        else if (to_hit)
          state_nx = S_FINISH;
        else
          state_nx = S_RST_ACK;
      S_WAIT_WORD:
        if (s_valid) state_nx = S_WR_REQ;
      S_WR_REQ, S_WR_ACK:
        if (wbm_ack_i)
          state_nx = (wl_inc >= len_q) ? S_FINISH : S_WAIT_WORD;
        else if (to_hit)
          state_nx = S_FINISH;
        else
          state_nx = S_WR_ACK;
      S_FINISH:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state  <= S_IDLE;
      midx_q <= '0;
      len_q  <= '0;
      wl_q   <= '0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        midx_q <= tgt_mindex;
        len_q  <= (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
        wl_q   <= '0;
      end
      if (state == S_WAIT_WORD && s_valid)
        data_q <= s_data;
      if (is_wr && wbm_ack_i)
        wl_q <= wl_inc;
    end
  end

  // Bus outputs are pure decodes of state, so reset clears them at once.
  assign wbm_cyc_o = bus_req;
  assign wbm_stb_o = bus_req;
  assign wbm_we_o  = bus_req;
  assign wbm_sel_o = bus_req ? 4'hF : 4'h0;
  assign wbm_adr_o = !bus_req ? '0 :
                     pio_adr(BASE_ADDR, midx_q,
                             is_rst ? ACT_CTRL : ACT_INSTR);
  assign wbm_dat_o = !bus_req ? '0 :
                     is_rst ? RST_WORD : {16'h0000, data_q};

  assign s_ready      = (state == S_WAIT_WORD);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_FINISH);
  assign words_loaded = wl_q;

endmodule
